// File: rtl/vip_raw_bridge_decode.sv
// rtl/vip_raw_bridge_decode.sv - VIP (Avalon-ST Video) sink to raw pixel stream bridge.
// Decodes control packets into frame geometry and strips video headers into a framed pixel stream.
module vip_raw_bridge_decode #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          DATA_BITS      = 8,
  parameter int          DATA_PLANES    = 1,
  parameter logic [15:0] VIP_WIDTH      = 16'd720,
  parameter logic [15:0] VIP_HEIGHT     = 16'd576,
  parameter logic [3:0]  VIP_INTERLACED = 4'b0010
) (
  input  logic                  av_clk,
  input  logic                  av_rst_n,
  input  logic [2:0]            av_address,
  input  logic                  av_read,
  input  logic                  av_write,
  input  logic [31:0]           av_writedata,
  output logic [31:0]           av_readdata,
  output logic                  av_readdatavalid,
  output logic                  av_waitrequest,
  output logic                  av_irq,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  input  logic                  din_sop,
  input  logic                  din_eop,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  raw_valid,
  input  logic                  raw_ready,
  output logic                  raw_fs,
  output logic                  raw_eof
);

  typedef enum logic [1:0] {S_IDLE, S_VIDEO, S_CTRL, S_DISCARD} state_t;

  state_t      state, state_nx;
  logic        rdy_en;
  logic        go_r, irqen_r, irq_r, err_size_r, err_ctrl_r, first_pix;
  logic [15:0] width_r, height_r;
  logic [3:0]  interlaced_r;
  logic [31:0] pix_cnt, last_cnt, pix_inc, frame_size, rd_mux;
  logic [3:0]  nib_cnt, nib_sum, nib_nx, pkt_type;
  logic [35:0] shadow, shadow_nx;
  logic        acc;
  logic        unused_wdata;

  assign unused_wdata   = &{1'b0, av_writedata[31:2]};
  assign av_waitrequest = 1'b0;
  assign av_irq         = irqen_r & irq_r;
  // Output register is a single slot: stall the sink only when it is full and not draining.
  assign din_ready  = rdy_en & ((state != S_VIDEO) | ~raw_valid | raw_ready);
  assign acc        = din_valid & din_ready;
  assign pkt_type   = din_data[3:0];
  assign pix_inc    = (pix_cnt == 32'hFFFF_FFFF) ? pix_cnt : pix_cnt + 32'd1;
  assign frame_size = {16'd0, width_r} * {16'd0, height_r};
  assign nib_sum    = nib_cnt + 4'(DATA_PLANES);
  assign nib_nx     = (nib_sum > 4'd9) ? 4'd9 : nib_sum;

  // Nibble n of a control packet lands at shadow[35-4n -: 4]: W, H, then I.
  always_comb begin
    shadow_nx = shadow;
    for (int k = 0; k < DATA_PLANES; k++) begin
      if (int'(nib_cnt) + k < 9)
        shadow_nx[35 - 4*(int'(nib_cnt) + k) -: 4] = din_data[k*DATA_BITS +: 4];
    end
  end

  always_comb begin
    state_nx = state;
    if (acc) begin
      if (din_sop) begin
        if (din_eop)                       state_nx = S_IDLE;
        else if (pkt_type == 4'h0 && go_r) state_nx = S_VIDEO;
        else if (pkt_type == 4'hF)         state_nx = S_CTRL;
        else                               state_nx = S_DISCARD;
      end else if (din_eop) begin
        state_nx = S_IDLE;
      end
    end
  end

  always_ff @(posedge av_clk or negedge av_rst_n) begin
    if (!av_rst_n) begin
      state        <= S_IDLE;
      rdy_en       <= 1'b0;
      go_r         <= 1'b1;
      irqen_r      <= 1'b0;
      irq_r        <= 1'b0;
      err_size_r   <= 1'b0;
      err_ctrl_r   <= 1'b0;
      first_pix    <= 1'b0;
      width_r      <= VIP_WIDTH;
      height_r     <= VIP_HEIGHT;
      interlaced_r <= VIP_INTERLACED;
      pix_cnt      <= '0;
      last_cnt     <= '0;
      nib_cnt      <= '0;
      shadow       <= '0;
      raw_data     <= '0;
      raw_valid    <= 1'b0;
      raw_fs       <= 1'b0;
      raw_eof      <= 1'b0;
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;
      // Register writes first so that same-cycle stream events (set) take priority.
      if (av_write) begin
        case (av_address)
          3'd0: begin go_r <= av_writedata[0]; irqen_r <= av_writedata[1]; end
          3'd1: begin err_size_r <= 1'b0; err_ctrl_r <= 1'b0; end
          3'd2: irq_r <= 1'b0;
          default: ;
        endcase
      end
      if (raw_valid && raw_ready) begin
        raw_valid <= 1'b0;
        raw_fs    <= 1'b0;
        raw_eof   <= 1'b0;
      end
      if (acc) begin
        if (din_sop) begin
          if (state == S_VIDEO) err_size_r <= 1'b1;
          if (state == S_CTRL)  err_ctrl_r <= 1'b1;
          if (pkt_type == 4'hF && din_eop) err_ctrl_r <= 1'b1;
          pix_cnt   <= '0;
          nib_cnt   <= '0;
          first_pix <= 1'b1;
        end else if (state == S_VIDEO) begin
          raw_data  <= din_data;
          raw_valid <= 1'b1;
          raw_fs    <= first_pix;
          raw_eof   <= din_eop;
          first_pix <= 1'b0;
          pix_cnt   <= pix_inc;
          if (din_eop) begin
            last_cnt <= pix_inc;
            irq_r    <= 1'b1;
            if (pix_inc != frame_size) err_size_r <= 1'b1;
          end
        end else if (state == S_CTRL) begin
          shadow  <= shadow_nx;
          nib_cnt <= nib_nx;
          if (din_eop) begin
            if (nib_nx == 4'd9) begin
              width_r      <= shadow_nx[35:20];
              height_r     <= shadow_nx[19:4];
              interlaced_r <= shadow_nx[3:0];
            end else begin
              err_ctrl_r <= 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (av_address)
      3'd0: rd_mux = {30'd0, irqen_r, go_r};
      3'd1: rd_mux = {29'd0, err_ctrl_r, err_size_r, state == S_VIDEO};
      3'd2: rd_mux = {31'd0, irq_r};
      3'd3: rd_mux = {16'd0, width_r};
      3'd4: rd_mux = {16'd0, height_r};
      3'd5: rd_mux = {28'd0, interlaced_r};
      3'd6: rd_mux = last_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge av_clk or negedge av_rst_n) begin
    if (!av_rst_n) begin
      av_readdata      <= '0;
      av_readdatavalid <= 1'b0;
    end else begin
      av_readdatavalid <= av_read;
      if (av_read) av_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_vip_raw_bridge_decode.sv
// tb/tb_vip_raw_bridge_decode.sv - randomized bench for vip_raw_bridge_decode.
// Packet-level model: expected pixel queue plus register image updated per packet.
module tb_vip_raw_bridge_decode;

  localparam int DW = 8;

  logic          av_clk, av_rst_n;
  logic [2:0]    av_address;
  logic          av_read, av_write;
  logic [31:0]   av_writedata, av_readdata;
  logic          av_readdatavalid, av_waitrequest, av_irq;
  logic [DW-1:0] din_data, raw_data;
  logic          din_valid, din_sop, din_eop, din_ready;
  logic          raw_valid, raw_ready, raw_fs, raw_eof;

  vip_raw_bridge_decode dut (
    .av_clk(av_clk), .av_rst_n(av_rst_n), .av_address(av_address), .av_read(av_read),
    .av_write(av_write), .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid), .av_waitrequest(av_waitrequest), .av_irq(av_irq),
    .din_data(din_data), .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop),
    .din_ready(din_ready), .raw_data(raw_data), .raw_valid(raw_valid), .raw_ready(raw_ready),
    .raw_fs(raw_fs), .raw_eof(raw_eof)
  );

  initial av_clk = 1'b0;
  always #5 av_clk = ~av_clk;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_w, m_h, m_i, m_lastcnt;
  bit          m_es, m_ec, m_go, m_irq, m_irqen;
  logic [9:0]  exp_q[$];
  bit          gaps, mon_en, chk_rdy;
  int          ready_mode;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: drives raw_ready, checks hold-while-stalled and pixel order.
  initial begin
    bit         stall_prev;
    logic [9:0] held, e;
    raw_ready  = 1'b0;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge av_clk);
      case (ready_mode)
        0:       raw_ready = ($urandom_range(0, 3) != 0);
        1:       raw_ready = 1'b1;
        default: raw_ready = 1'b0;
      endcase
      #1;
      if (!mon_en) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          check_eq("hold_valid", raw_valid, 1);
          check_eq("hold_data", {raw_fs, raw_eof, raw_data}, held);
        end
        if (raw_valid && raw_ready) begin
          check_eq("pix_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("pix", {raw_fs, raw_eof, raw_data}, e);
          end
        end
        stall_prev = raw_valid && !raw_ready;
        held = {raw_fs, raw_eof, raw_data};
      end
    end
  end

  task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge av_clk);
    av_address = a; av_writedata = d; av_write = 1'b1;
    @(negedge av_clk);
    av_write = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge av_clk);
    av_address = a; av_read = 1'b1;
    @(negedge av_clk);
    av_read = 1'b0;
    check_eq("rdvalid", av_readdatavalid, 1);
    check_eq(tag, av_readdata, exp);
  endtask

  task automatic check_model();
    check_reg("width", 3, m_w);
    check_reg("height", 4, m_h);
    check_reg("interlaced", 5, m_i);
    check_reg("lastcnt", 6, m_lastcnt);
    check_reg("status", 1, {29'd0, m_ec, m_es, 1'b0});
    check_reg("irq", 2, {31'd0, m_irq});
    check_eq("av_irq", av_irq, m_irq & m_irqen);
  endtask

  task automatic clear_errors();
    mm_write(1, 0);
    m_es = 0; m_ec = 0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit sop, input bit eop, input bit wr_clr);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < 500) begin
      @(negedge av_clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        din_valid = 1'b0; av_write = 1'b0;
      end else begin
        din_valid = 1'b1; din_data = d; din_sop = sop; din_eop = eop;
        if (wr_clr) begin av_write = 1'b1; av_address = 3'd2; end
        #2;
        if (din_ready) done = 1;
        if (chk_rdy) check_eq("din_ready_discard", din_ready, 1);
      end
      n++;
    end
    check_eq("beat_accepted", done, 1);
  endtask

  task automatic go_idle();
    @(negedge av_clk);
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0; av_write = 1'b0;
  endtask

  task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] i, input int nnib);
    logic [35:0] nibs;
    logic [3:0]  nib;
    nibs = {w, h, i};
    send_beat({4'($urandom), 4'hF}, 1, nnib == 0, 0);
    for (int k = 0; k < nnib; k++) begin
      nib = (k < 9) ? nibs[35 - 4*k -: 4] : 4'($urandom);
      send_beat({4'($urandom), nib}, 0, k == nnib - 1, 0);
    end
    go_idle();
    if (nnib >= 9) begin m_w = w; m_h = h; m_i = i; end
    else m_ec = 1;
  endtask

  task automatic send_video(input int npix, input bit wr_clr_eop);
    logic [DW-1:0] d;
    bit last;
    send_beat({4'($urandom), 4'h0}, 1, 0, 0);
    for (int p = 0; p < npix; p++) begin
      d = DW'($urandom);
      last = (p == npix - 1);
      if (m_go) exp_q.push_back({p == 0, last, d});
      send_beat(d, 0, last, wr_clr_eop && last);
    end
    go_idle();
    if (m_go) begin
      m_lastcnt = npix;
      if (npix != m_w * m_h) m_es = 1;
      m_irq = 1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || raw_valid) && n < 2000) begin
      @(negedge av_clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic model_reset();
    m_w = 720; m_h = 576; m_i = 2; m_lastcnt = 0;
    m_es = 0; m_ec = 0; m_go = 1; m_irq = 0; m_irqen = 0;
  endtask

  initial begin
    int w, h, np;
    model_reset();
    av_rst_n = 1'b0; av_address = '0; av_read = 0; av_write = 0; av_writedata = '0;
    din_data = '0; din_valid = 0; din_sop = 0; din_eop = 0;
    gaps = 1; mon_en = 0; chk_rdy = 0; ready_mode = 0;
    repeat (3) @(negedge av_clk);
    check_eq("rst_din_ready", din_ready, 0);
    check_eq("rst_raw_valid", raw_valid, 0);
    check_eq("rst_raw_data", raw_data, 0);
    check_eq("rst_readdata", av_readdata, 0);
    check_eq("rst_readdatavalid", av_readdatavalid, 0);
    av_rst_n = 1'b1;
    mon_en = 1;
    check_model();
    check_reg("ctrl_reset", 0, 1);
    check_reg("addr7", 7, 0);
    mm_write(0, 3); m_irqen = 1;

    send_ctrl(720, 576, 2, 9);
    check_model();

    send_ctrl(4, 2, 4'($urandom), 9);
    send_video(8, 0);
    drain();
    check_model();

    fork
      send_video(8, 0);
      begin
        repeat (3) @(negedge av_clk);
        ready_mode = 2;
        repeat (3) begin
          @(negedge av_clk); #2;
          check_eq("din_ready_stall", din_ready, !raw_valid);
        end
        ready_mode = 0;
      end
    join
    drain();

    send_video(5, 0);
    drain();
    check_model();
    clear_errors();

    send_ctrl(16'($urandom), 16'($urandom), 4'($urandom), 6);
    check_model();
    clear_errors();

    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 3);
      send_ctrl(16'(w), 16'(h), 4'($urandom), $urandom_range(9, 11));
      np = ($urandom_range(0, 1) == 0) ? w * h : $urandom_range(1, w * h + 2);
      send_video(np, 0);
      drain();
      check_model();
      clear_errors();
    end

    // Abort: new ctrl header arrives after three pixels of a video packet.
    send_beat(8'h00, 1, 0, 0);
    for (int p = 0; p < 3; p++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      exp_q.push_back({p == 0, 1'b0, d});
      send_beat(d, 0, 0, 0);
    end
    m_es = 1;
    send_ctrl(3, 3, 4'h1, 9);
    drain();
    check_model();
    clear_errors();

    chk_rdy = 1;
    send_beat(8'h53, 1, 0, 0);
    for (int p = 0; p < 4; p++) send_beat(DW'($urandom), 0, p == 3, 0);
    go_idle();
    mm_write(0, 2); m_go = 0;
    send_video(4, 0);
    send_video(9, 0);
    chk_rdy = 0;
    drain();
    check_model();
    mm_write(0, 3); m_go = 1;

    mm_write(2, 0); m_irq = 0;
    send_ctrl(2, 2, 4'h0, 9);
    check_model();
    gaps = 0; ready_mode = 1;
    send_video(4, 1);
    gaps = 1; ready_mode = 0;
    drain();
    check_model();
    mm_write(2, 0); m_irq = 0;
    check_model();

    mon_en = 0;
    send_beat(8'h00, 1, 0, 0);
    send_beat(8'hA5, 0, 0, 0);
    send_beat(8'h5A, 0, 0, 0);
    @(negedge av_clk);
    av_rst_n = 1'b0;
    din_valid = 1'b0;
    #1;
    check_eq("rst2_din_ready", din_ready, 0);
    check_eq("rst2_raw_valid", raw_valid, 0);
    check_eq("rst2_raw_out", {raw_fs, raw_eof, raw_data}, 0);
    check_eq("rst2_readdatavalid", av_readdatavalid, 0);
    check_eq("rst2_readdata", av_readdata, 0);
    check_eq("rst2_irq", av_irq, 0);
    exp_q.delete();
    model_reset();
    @(negedge av_clk);
    av_rst_n = 1'b1;
    mon_en = 1;
    check_model();
    check_reg("ctrl_reset2", 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
